// File: rtl/encrypt_sequencer.sv
// rtl/encrypt_sequencer.sv - TEA encrypt micro-op sequencer driving an external regfile/ALU datapath
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a run (only looked at while idle)
//   hold              stall; freezes the sequencer while it is busy
//   RA1, RA2          register-file read addresses (operand A, operand B)
//   OPER              ALU op: 0 ADD, 1 SUB, 2 XOR, 3 SHL4, 4 SHR5
//   WA, WE            register-file write address and enable
//   busy, done        busy during INIT/RUN; done is a one-cycle completion pulse
//   step, round       current micro-step (0..16) and round index (0..ROUNDS-1)

module encrypt_sequencer #(
    parameter int ROUNDS = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       hold,
    output logic [3:0] RA1,
    output logic [3:0] RA2,
    output logic [2:0] OPER,
    output logic [3:0] WA,
    output logic       WE,
    output logic       busy,
    output logic       done,
    output logic [4:0] step,
    output logic [4:0] round
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_SHL4 = 3'd3;
    localparam logic [2:0] OP_SHR5 = 3'd4;

    localparam logic [4:0] LAST_STEP  = 5'd16;
    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

    state_t     state, state_nx;
    logic [4:0] step_q, step_nx;
    logic [4:0] round_q, round_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            step_q  <= 5'd0;
            round_q <= 5'd0;
        end else begin
            state   <= state_nx;
            step_q  <= step_nx;
            round_q <= round_nx;
        end
    end

    always_comb begin
        state_nx = state;
        step_nx  = step_q;
        round_nx = round_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_INIT;
                    step_nx  = 5'd0;
                    round_nx = 5'd0;
                end
            end
            S_INIT: begin
                if (!hold) begin
                    state_nx = S_RUN;
                    step_nx  = 5'd0;
                    round_nx = 5'd0;
                end
            end
            S_RUN: begin
                if (!hold) begin
                    if (step_q == LAST_STEP) begin
                        step_nx = 5'd0;
                        if (round_q == LAST_ROUND) begin
                            state_nx = S_DONE;
                            round_nx = 5'd0;
                        end else begin
                            round_nx = round_q + 5'd1;
                        end
                    end else begin
                        step_nx = step_q + 5'd1;
                    end
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
                step_nx  = 5'd0;
                round_nx = 5'd0;
            end
            default: begin
                state_nx = S_IDLE;
                step_nx  = 5'd0;
                round_nx = 5'd0;
            end
        endcase
    end

    // Micro-op decode looks only at registered state/step so the datapath
    // addresses never glitch with start/hold; only WE sees hold directly.
    // Steps 1..8 update v0 (R0) from v1, steps 9..16 update v1 (R1) from the
    // new v0, using R8/R9 as scratch.
    always_comb begin
        RA1  = 4'd0;
        RA2  = 4'd0;
        OPER = OP_ADD;
        WA   = 4'd0;
        if (state == S_INIT) begin
            {RA1, RA2, OPER, WA} = {4'd6, 4'd6, OP_XOR, 4'd6};
        end else if (state == S_RUN) begin
            case (step_q)
                5'd0:    {RA1, RA2, OPER, WA} = {4'd6, 4'd7, OP_ADD,  4'd6};
                5'd1:    {RA1, RA2, OPER, WA} = {4'd1, 4'd1, OP_SHL4, 4'd8};
                5'd2:    {RA1, RA2, OPER, WA} = {4'd8, 4'd2, OP_ADD,  4'd8};
                5'd3:    {RA1, RA2, OPER, WA} = {4'd1, 4'd6, OP_ADD,  4'd9};
                5'd4:    {RA1, RA2, OPER, WA} = {4'd8, 4'd9, OP_XOR,  4'd8};
                5'd5:    {RA1, RA2, OPER, WA} = {4'd1, 4'd1, OP_SHR5, 4'd9};
                5'd6:    {RA1, RA2, OPER, WA} = {4'd9, 4'd3, OP_ADD,  4'd9};
                5'd7:    {RA1, RA2, OPER, WA} = {4'd8, 4'd9, OP_XOR,  4'd8};
                5'd8:    {RA1, RA2, OPER, WA} = {4'd0, 4'd8, OP_ADD,  4'd0};
                5'd9:    {RA1, RA2, OPER, WA} = {4'd0, 4'd0, OP_SHL4, 4'd8};
                5'd10:   {RA1, RA2, OPER, WA} = {4'd8, 4'd4, OP_ADD,  4'd8};
                5'd11:   {RA1, RA2, OPER, WA} = {4'd0, 4'd6, OP_ADD,  4'd9};
                5'd12:   {RA1, RA2, OPER, WA} = {4'd8, 4'd9, OP_XOR,  4'd8};
                5'd13:   {RA1, RA2, OPER, WA} = {4'd0, 4'd0, OP_SHR5, 4'd9};
                5'd14:   {RA1, RA2, OPER, WA} = {4'd9, 4'd5, OP_ADD,  4'd9};
                5'd15:   {RA1, RA2, OPER, WA} = {4'd8, 4'd9, OP_XOR,  4'd8};
                5'd16:   {RA1, RA2, OPER, WA} = {4'd1, 4'd8, OP_ADD,  4'd1};
                default: {RA1, RA2, OPER, WA} = {4'd0, 4'd0, OP_ADD,  4'd0};
            endcase
        end
    end

    assign busy  = (state == S_INIT) || (state == S_RUN);
    assign done  = (state == S_DONE);
    assign WE    = busy && !hold;
    assign step  = step_q;
    assign round = round_q;

endmodule

// File: tb/tb_encrypt_sequencer.sv
// tb/tb_encrypt_sequencer.sv - randomized self-checking bench for encrypt_sequencer against a TEA reference

module tb_encrypt_sequencer;

    localparam int          R     = 32;
    localparam logic [31:0] DELTA = 32'h9E3779B9;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       start  = 1'b0;
    logic       hold   = 1'b0;
    logic       start1 = 1'b0;
    logic       hold1  = 1'b0;

    logic [3:0] ra1, ra2, wa;
    logic [2:0] oper;
    logic       we, busy, done;
    logic [4:0] step, round;

    logic [3:0] ra1_1, ra2_1, wa_1;
    logic [2:0] oper_1;
    logic       we_1, busy_1, done_1;
    logic [4:0] step_1, round_1;

    encrypt_sequencer #(.ROUNDS(R)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
        .RA1(ra1), .RA2(ra2), .OPER(oper), .WA(wa), .WE(we),
        .busy(busy), .done(done), .step(step), .round(round)
    );

    encrypt_sequencer #(.ROUNDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .hold(hold1),
        .RA1(ra1_1), .RA2(ra2_1), .OPER(oper_1), .WA(wa_1), .WE(we_1),
        .busy(busy_1), .done(done_1), .step(step_1), .round(round_1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a ^ b;
            3'd3:    return a << 4;
            3'd4:    return a >> 5;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [63:0] tea(input logic [31:0] v0_i, input logic [31:0] v1_i,
                                        input logic [31:0] k0, input logic [31:0] k1,
                                        input logic [31:0] k2, input logic [31:0] k3,
                                        input int rounds);
        logic [31:0] v0, v1, sum;
        v0  = v0_i;
        v1  = v1_i;
        sum = 32'd0;
        for (int i = 0; i < rounds; i++) begin
            sum = sum + DELTA;
            v0  = v0 + (((v1 << 4) + k0) ^ (v1 + sum) ^ ((v1 >> 5) + k1));
            v1  = v1 + (((v0 << 4) + k2) ^ (v0 + sum) ^ ((v0 >> 5) + k3));
        end
        return {v0, v1};
    endfunction

    // Behavioural register file + ALU fed by the sequencer's micro-ops.
    logic [31:0] rf [16];
    logic        ld_go = 1'b0;
    logic [31:0] ld_v [6];
    int we_cnt, done_cnt, hold_we_cnt, stall_cnt, cyc, cyc0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ld_go) begin
            for (int i = 0; i < 6; i++) rf[i] <= ld_v[i];
            rf[6]       <= 32'hDEADBEEF;
            rf[7]       <= DELTA;
            rf[8]       <= $urandom;
            rf[9]       <= $urandom;
            we_cnt      <= 0;
            done_cnt    <= 0;
            hold_we_cnt <= 0;
            stall_cnt   <= 0;
        end else begin
            if (we) begin
                rf[wa] <= alu(rf[ra1], rf[ra2], oper);
                we_cnt <= we_cnt + 1;
            end
            if (done)        done_cnt    <= done_cnt + 1;
            if (we && hold)  hold_we_cnt <= hold_we_cnt + 1;
            if (busy && hold) stall_cnt  <= stall_cnt + 1;
        end
    end

    logic [14:0] trace_exp [18];

    task automatic load(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] k0,
                        input logic [31:0] k1, input logic [31:0] k2, input logic [31:0] k3);
        @(negedge clk);
        ld_v[0] = v0; ld_v[1] = v1; ld_v[2] = k0; ld_v[3] = k1; ld_v[4] = k2; ld_v[5] = k3;
        ld_go = 1'b1;
        @(negedge clk);
        ld_go = 1'b0;
    endtask

    task automatic kick(input bit rnd);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 cyc0 = cyc;
        @(negedge clk);
        start = 1'b0;
        hold  = rnd && ($urandom_range(0, 2) == 0);
    endtask

    task automatic wait_done(input string tag, input bit rnd, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = -1;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen  = 1'b1;
                lat   = cyc - cyc0;
                hold  = 1'b0;
                start = 1'b0;
            end else if (rnd) begin
                hold  = ($urandom_range(0, 5) == 0);
                start = busy && (round < 5'(R - 2)) && ($urandom_range(0, 19) == 0);
            end
        end
        if (!seen) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_at(input string tag, input logic [4:0] r, input logic [4:0] s);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (busy && round == r && step == s) found = 1'b1;
        end
        check({tag, "_reach"}, 64'(found), 64'd1);
    endtask

    task automatic check_result(input string tag, input logic [63:0] exp, input int lat_got, input int lat_exp);
        repeat (3) @(negedge clk);
        check({tag, "_v0"}, rf[0], exp[63:32]);
        check({tag, "_v1"}, rf[1], exp[31:0]);
        check({tag, "_lat"}, 64'(lat_got), 64'(lat_exp));
        check({tag, "_we_cnt"}, 64'(we_cnt), 64'd545);
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check({tag, "_idle"}, {busy, done}, 2'b00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, snap;
        logic [31:0] v0, v1, k0, k1, k2, k3;
        logic [63:0] zero_ct;

        trace_exp[0]  = {4'd6, 4'd6, 3'd2, 4'd6};
        trace_exp[1]  = {4'd6, 4'd7, 3'd0, 4'd6};
        trace_exp[2]  = {4'd1, 4'd1, 3'd3, 4'd8};
        trace_exp[3]  = {4'd8, 4'd2, 3'd0, 4'd8};
        trace_exp[4]  = {4'd1, 4'd6, 3'd0, 4'd9};
        trace_exp[5]  = {4'd8, 4'd9, 3'd2, 4'd8};
        trace_exp[6]  = {4'd1, 4'd1, 3'd4, 4'd9};
        trace_exp[7]  = {4'd9, 4'd3, 3'd0, 4'd9};
        trace_exp[8]  = {4'd8, 4'd9, 3'd2, 4'd8};
        trace_exp[9]  = {4'd0, 4'd8, 3'd0, 4'd0};
        trace_exp[10] = {4'd0, 4'd0, 3'd3, 4'd8};
        trace_exp[11] = {4'd8, 4'd4, 3'd0, 4'd8};
        trace_exp[12] = {4'd0, 4'd6, 3'd0, 4'd9};
        trace_exp[13] = {4'd8, 4'd9, 3'd2, 4'd8};
        trace_exp[14] = {4'd0, 4'd0, 3'd4, 4'd9};
        trace_exp[15] = {4'd9, 4'd5, 3'd0, 4'd9};
        trace_exp[16] = {4'd8, 4'd9, 3'd2, 4'd8};
        trace_exp[17] = {4'd1, 4'd8, 3'd0, 4'd1};

        zero_ct = {32'h41EA3A0A, 32'h94BAA940};
        check("model_zero_vector", tea(0, 0, 0, 0, 0, 0, R), zero_ct);

        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #2 check("reset_outputs", {ra1, ra2, oper, wa, we, busy, done, step, round}, 28'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", {busy, done, we, step, round}, 13'd0);

        // Single-round instance: full micro-op trace and latency.
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1 cyc0 = cyc;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 18; i++) begin
            check($sformatf("trace_%0d", i), {ra1_1, ra2_1, oper_1, wa_1, we_1}, {trace_exp[i], 1'b1});
            @(negedge clk);
        end
        check("trace_done", 64'(done_1), 64'd1);
        check("trace_lat", 64'(cyc - cyc0), 64'd18);
        @(negedge clk);
        check("trace_idle", {done_1, busy_1, ra1_1, ra2_1, oper_1, wa_1}, 17'd0);

        // Zero key/plaintext reference run.
        load(0, 0, 0, 0, 0, 0);
        kick(1'b0);
        wait_done("zero", 1'b0, lat);
        check_result("zero", zero_ct, lat, 545);

        // Five-cycle stall at round 3 step 9.
        load(0, 0, 0, 0, 0, 0);
        kick(1'b0);
        wait_at("hold", 5'd3, 5'd9);
        hold = 1'b1;
        #1 check("hold_we", 64'(we), 64'd0);
        repeat (5) begin
            @(posedge clk);
            #1 check("hold_frozen", {round, step, ra1, ra2, oper, wa, we},
                     {5'd3, 5'd9, 4'd0, 4'd0, 3'd3, 4'd8, 1'b0});
        end
        @(negedge clk);
        hold = 1'b0;
        wait_done("hold", 1'b0, lat);
        check_result("hold", zero_ct, lat, 550);

        // start pulses mid-run and in the DONE cycle must be ignored.
        load(0, 0, 0, 0, 0, 0);
        kick(1'b0);
        wait_at("restart", 5'd10, 5'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("restart", 1'b0, lat);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_result("restart", zero_ct, lat, 545);

        // Reset mid-run: immediate abort, then a clean rerun.
        load(0, 0, 0, 0, 0, 0);
        kick(1'b0);
        wait_at("rst", 5'd15, 5'd4);
        #2 rst_n = 1'b0;
        snap = we_cnt;
        #1 check("rst_async", {ra1, ra2, oper, wa, we, busy, done, step, round}, 28'd0);
        repeat (3) @(negedge clk);
        check("rst_no_write", 64'(we_cnt), 64'(snap));
        rst_n = 1'b1;
        load(0, 0, 0, 0, 0, 0);
        kick(1'b0);
        wait_done("rst_rerun", 1'b0, lat);
        check_result("rst_rerun", zero_ct, lat, 545);

        // Random keys/plaintext with random stalls and stray start pulses.
        for (int n = 0; n < 6; n++) begin
            v0 = $urandom; v1 = $urandom;
            k0 = $urandom; k1 = $urandom; k2 = $urandom; k3 = $urandom;
            load(v0, v1, k0, k1, k2, k3);
            kick(1'b1);
            wait_done($sformatf("rnd%0d", n), 1'b1, lat);
            repeat (1) @(negedge clk);
            check_result($sformatf("rnd%0d", n), tea(v0, v1, k0, k1, k2, k3, R), lat, 545 + stall_cnt);
            check($sformatf("rnd%0d_we_during_hold", n), 64'(hold_we_cnt), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
